// File: rtl/arccos_search_pkg.sv
// Shared S3.4 fixed-point constants and FSM encodings for the arccos bisection search.
package arccos_search_pkg;

  localparam int TOTAL_WIDTH = 8;
  localparam int FRAC_BITS   = 4;
  localparam int ONE         = 1 << FRAC_BITS;
  // pi in S3.4, floor(3.14159 * 16)
  localparam int X_MAX       = 50;
  localparam int ITER        = 6;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/arccos_search_cosine_approx.sv
// Combinational S3.4 cosine over 0..pi: each entry is 16*cos(x/16) truncated toward zero,
// so the table never reaches -1.0 and is non-increasing across the whole range.
module cosine_approx #(
  parameter int TOTAL_WIDTH = 8
) (
  input  logic        [TOTAL_WIDTH-1:0] x,
  output logic signed [TOTAL_WIDTH-1:0] c
);

  localparam int LUT_LAST = 50;

  localparam logic signed [7:0] COS_LUT [0:LUT_LAST] = '{
     8'sd16,  8'sd15,  8'sd15,  8'sd15,  8'sd15,  8'sd15,  8'sd14,  8'sd14,  8'sd14,  8'sd13,
     8'sd12,  8'sd12,  8'sd11,  8'sd11,  8'sd10,  8'sd9,   8'sd8,   8'sd7,   8'sd6,   8'sd5,
     8'sd5,   8'sd4,   8'sd3,   8'sd2,   8'sd1,   8'sd0,   8'sd0,  -8'sd1,  -8'sd2,  -8'sd3,
    -8'sd4,  -8'sd5,  -8'sd6,  -8'sd7,  -8'sd8,  -8'sd9,  -8'sd10, -8'sd10, -8'sd11, -8'sd12,
    -8'sd12, -8'sd13, -8'sd13, -8'sd14, -8'sd14, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15,
    -8'sd15
  };

  logic [5:0] idx;
  logic       in_range;

  always_comb begin
    idx      = x[5:0];
    in_range = (x <= TOTAL_WIDTH'(LUT_LAST));
    // Angles past pi are never probed by the search; hold the pi value there.
    if (in_range) begin
      c = TOTAL_WIDTH'(COS_LUT[idx]);
    end else begin
      c = TOTAL_WIDTH'(COS_LUT[LUT_LAST]);
    end
  end

endmodule

// File: rtl/arccos_search.sv
// Bisection inverse of cosine_approx: returns the smallest S3.4 angle in 0..pi whose
// cosine is at or below the clamped request, with fixed ITER-cycle latency.
module arccos_search #(
  parameter int TOTAL_WIDTH = arccos_search_pkg::TOTAL_WIDTH,
  parameter int FRAC_BITS   = arccos_search_pkg::FRAC_BITS,
  parameter int ONE         = arccos_search_pkg::ONE,
  parameter int X_MAX       = arccos_search_pkg::X_MAX,
  parameter int ITER        = arccos_search_pkg::ITER
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [TOTAL_WIDTH-1:0] y_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [TOTAL_WIDTH-1:0] x_out,
  output logic                          sat
);

  import arccos_search_pkg::state_t;
  import arccos_search_pkg::IDLE;
  import arccos_search_pkg::SEARCH;
  import arccos_search_pkg::DONE;
  import arccos_search_pkg::CNT_W;

  // A zero ONE override falls back to the value implied by the fraction width.
  localparam int ONE_EFF = (ONE != 0) ? ONE : (1 << FRAC_BITS);

  localparam logic signed [TOTAL_WIDTH-1:0] POS_ONE  = TOTAL_WIDTH'(ONE_EFF);
  localparam logic signed [TOTAL_WIDTH-1:0] NEG_ONE  = TOTAL_WIDTH'(-ONE_EFF);
  localparam logic        [TOTAL_WIDTH-1:0] X_MAX_W  = TOTAL_WIDTH'(X_MAX);
  localparam logic        [CNT_W-1:0]       CNT_LAST = CNT_W'(ITER - 1);

  state_t                          state_q, state_d;
  logic signed [TOTAL_WIDTH-1:0]   y_q, y_d;
  logic        [TOTAL_WIDTH-1:0]   lo_q, lo_d;
  logic        [TOTAL_WIDTH-1:0]   hi_q, hi_d;
  logic        [CNT_W-1:0]         cnt_q, cnt_d;
  logic                            sat_q, sat_d;

  logic        [TOTAL_WIDTH-1:0]   mid_sum;
  logic        [TOTAL_WIDTH-1:0]   mid;
  logic signed [TOTAL_WIDTH-1:0]   c;
  logic                            y_above;
  logic                            y_below;

  cosine_approx #(
    .TOTAL_WIDTH (TOTAL_WIDTH)
  ) u_cosine_approx (
    .x (mid),
    .c (c)
  );

  always_comb begin
    mid_sum = lo_q + hi_q;
    mid     = mid_sum >> 1;
    y_above = (y_in > POS_ONE);
    y_below = (y_in < NEG_ONE);

    state_d = state_q;
    y_d     = y_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (y_above) begin
            y_d = POS_ONE;
          end else if (y_below) begin
            y_d = NEG_ONE;
          end else begin
            y_d = y_in;
          end
          sat_d   = y_above || y_below;
          lo_d    = '0;
          hi_d    = X_MAX_W;
          cnt_d   = '0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        // Lower-bound bisection: keep hi on a candidate, push lo past rejected angles.
        if (lo_q < hi_q) begin
          if (c > y_q) begin
            lo_d = mid + TOTAL_WIDTH'(1);
          end else begin
            hi_d = mid;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_out     = lo_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_arccos_search.sv
// Scoreboard bench for arccos_search: expected angles come from a real-valued cosine
// model scanned by brute force, pushed at request time and popped at each result.
module tb_arccos_search;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] y_in;
  logic              out_valid;
  logic              out_ready;
  logic        [7:0] x_out;
  logic              sat;

  typedef struct {
    int x;
    bit s;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;

  arccos_search dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int cos_model(input int x);
    return $rtoi(16.0 * $cos(real'(x) / 16.0));
  endfunction

  function automatic int ref_angle(input int y);
    int yc;
    yc = y;
    if (yc > 16)  yc = 16;
    if (yc < -16) yc = -16;
    for (int x = 0; x <= 50; x++) begin
      if (cos_model(x) <= yc) return x;
    end
    return 50;
  endfunction

  // Presents one request at a falling edge and records the expected result.
  task automatic send(input int y);
    exp_t e;
    int   k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready y=%0d in_ready=%b required 1", y, in_ready);
    end
    in_valid   = 1'b1;
    y_in       = 8'(y);
    accept_cyc = cyc;
    e.x = ref_angle(y);
    e.s = (y > 16) || (y < -16);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y_in      = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (x_out !== 8'd0)     begin failures++; $display("FAIL reset_x_out got=%0d exp=0", x_out); end
    checks++; if (sat !== 1'b0)       begin failures++; $display("FAIL reset_sat got=%b exp=0", sat); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int   ys [5] = '{16, 100, -101, 0, -16};
    int   fixed_x [5] = '{0, 0, 50, 25, 50};
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ys[i]);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin
        failures++;
        $display("FAIL basic_latency y=%0d got=%0d exp=6", ys[i], lat);
      end
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL basic_scoreboard_empty y=%0d got=0 entries exp=1", ys[i]);
      end else begin
        e = sb_q.pop_front();
        $display("txn basic y=%0d x_out=%0d sat=%b exp_x=%0d exp_sat=%b", ys[i], x_out, sat, e.x, e.s);
        checks++;
        if (x_out !== 8'(e.x)) begin failures++; $display("FAIL basic_x y=%0d got=%0d exp=%0d", ys[i], x_out, e.x); end
        checks++;
        if (sat !== e.s) begin failures++; $display("FAIL basic_sat y=%0d got=%b exp=%b", ys[i], sat, e.s); end
      end
      checks++;
      if (x_out !== 8'(fixed_x[i])) begin
        failures++;
        $display("FAIL basic_known_x y=%0d got=%0d exp=%0d", ys[i], x_out, fixed_x[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sweep;
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    for (int y = -101; y <= 100; y++) begin
      send(y);
      wait_result(lat);
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sweep_scoreboard_empty y=%0d got=0 entries exp=1", y);
      end else begin
        e = sb_q.pop_front();
        $display("txn sweep y=%0d x_out=%0d sat=%b exp_x=%0d exp_sat=%b lat=%0d", y, x_out, sat, e.x, e.s, lat);
        checks++;
        if (out_valid !== 1'b1 || x_out !== 8'(e.x)) begin
          failures++;
          $display("FAIL sweep_x y=%0d got=%0d valid=%b exp=%0d", y, x_out, out_valid, e.x);
        end
        checks++;
        if (sat !== e.s) begin failures++; $display("FAIL sweep_sat y=%0d got=%b exp=%b", y, sat, e.s); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    send(-40);
    wait_result(lat);
    e = sb_q.pop_front();
    $display("txn backpressure y=-40 x_out=%0d sat=%b exp_x=%0d exp_sat=%b", x_out, sat, e.x, e.s);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      y_in     = 8'sd0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1)  begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (x_out !== 8'(e.x))   begin failures++; $display("FAIL bp_x cyc=%0d got=%0d exp=%0d", i, x_out, e.x); end
      checks++; if (sat !== e.s)         begin failures++; $display("FAIL bp_sat cyc=%0d got=%b exp=%b", i, sat, e.s); end
      checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    repeat (8) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ignored_pulse out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    int   first_cyc;
    exp_t e;
    out_ready = 1'b1;
    send(8);
    first_cyc = accept_cyc;
    wait_result(lat);
    e = sb_q.pop_front();
    $display("txn b2b y=8 x_out=%0d sat=%b exp_x=%0d exp_sat=%b", x_out, sat, e.x, e.s);
    checks++; if (x_out !== 8'(e.x)) begin failures++; $display("FAIL b2b_x0 got=%0d exp=%0d", x_out, e.x); end
    @(negedge clk);
    send(-8);
    checks++;
    if (accept_cyc - first_cyc !== 8) begin
      failures++;
      $display("FAIL b2b_throughput got=%0d cycles exp=8", accept_cyc - first_cyc);
    end
    wait_result(lat);
    e = sb_q.pop_front();
    $display("txn b2b y=-8 x_out=%0d sat=%b exp_x=%0d exp_sat=%b", x_out, sat, e.x, e.s);
    checks++; if (x_out !== 8'(e.x)) begin failures++; $display("FAIL b2b_x1 got=%0d exp=%0d", x_out, e.x); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    send(-101);
    repeat (3) @(negedge clk);
    checks++; if (sat !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_sat got=%b exp=1", sat); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (x_out !== 8'd0)     begin failures++; $display("FAIL rst_mid_x_out got=%0d exp=0", x_out); end
    checks++; if (sat !== 1'b0)       begin failures++; $display("FAIL rst_mid_sat got=%b exp=0", sat); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    $display("txn reset_mid y=-101 discarded");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(-16);
    wait_result(lat);
    e = sb_q.pop_front();
    $display("txn reset_mid y=-16 x_out=%0d sat=%b exp_x=%0d lat=%0d", x_out, sat, e.x, lat);
    checks++; if (lat !== 6)         begin failures++; $display("FAIL rst_mid_latency got=%0d exp=6", lat); end
    checks++; if (x_out !== 8'd50)   begin failures++; $display("FAIL rst_mid_x got=%0d exp=50", x_out); end
    checks++; if (x_out !== 8'(e.x)) begin failures++; $display("FAIL rst_mid_model_x got=%0d exp=%0d", x_out, e.x); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d entries exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arccos_search.md
# arccos_search

Iterative inverse of the combinational `cosine_approx` block in the QFT fixed-point datapath. Accepts a signed S3.4 cosine value and returns the S3.4 angle x in [0, π] whose `cosine_approx(x)` first falls at or below it. It uses a bisection search over one internal `cosine_approx` instance. It sits between phase-estimation post-processing and the rotation-angle consumers, with valid/ready handshakes on both sides.

## Interface
- `TOTAL_WIDTH`, default 8 (from the fixed-point header): word width, signed S3.4.
- `FRAC_BITS`, default 4: fractional bits.
- `ONE`, default 16: the value 1.0 in S3.4.
- `X_MAX`, default 50: π in S3.4, floor(3.14159·16).
- `ITER`, default 6: bisection steps, where 2^ITER > X_MAX.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `y_in`  in  TOTAL_WIDTH  signed S3.4 cosine value.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `x_out`  out  TOTAL_WIDTH  signed S3.4 angle, range 0..X_MAX.
- `sat`  out  1  `y_in` was outside [-ONE, +ONE] and was clamped.

## Operation
- FSM states are IDLE, SEARCH and DONE. Reset state is IDLE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid`:
    - capture y = clamp(`y_in`, -ONE, +ONE);
    - set `sat` = (`y_in` > ONE) or (`y_in` < -ONE);
    - set lo = 0, hi = X_MAX, cnt = 0;
    - go to SEARCH.
- **SEARCH**, once per cycle:
  - mid = (lo+hi)>>1, unsigned, computed in TOTAL_WIDTH bits.
  - c = `cosine_approx`(mid).
  - If lo<hi:
    - if c > y (signed compare), lo ← mid+1;
    - else hi ← mid.
  - If lo==hi, registers hold.
  - cnt ← cnt+1. When cnt reaches ITER-1 the step still executes, then go to DONE.
- **DONE:**
  - `out_valid` = 1, `x_out` = lo.
  - On `out_ready`, go to IDLE.
  - `x_out` and `sat` hold until the next accepted request.
- **Result definition:** the smallest x in 0..X_MAX with `cosine_approx`(x) ≤ y. If no such x exists, the result is X_MAX. This is exact provided `cosine_approx` is non-increasing on 0..X_MAX; the block does not check that property.
- `in_ready` = 0 in SEARCH and DONE. There is no queuing, so requests presented then wait.
- **Reset values:** `in_ready`=1, `out_valid`=0, `x_out`=0, `sat`=0, state=IDLE.
- An `rst_n` assertion at any point (mid-SEARCH, or in DONE with `out_ready` low) returns to these values immediately and discards the pending result.

## Timing
- The request is accepted on rising edge E0 where `in_valid`&&`in_ready`.
- Search steps occur on edges E1..E_ITER. `out_valid` is high after edge E_ITER, giving a fixed latency of ITER (6) cycles independent of data.
- Back-to-back throughput is ITER+2 cycles per result: DONE handshake cycle plus IDLE accept cycle.
- A result handshake completes on the edge where `out_valid`&&`out_ready`. `in_ready` rises in the following cycle.
- Outputs are registered. `cosine_approx` is the only combinational path and lies inside the SEARCH loop (mid → c → compare → lo/hi).
- The clamp compare is done at full width before truncation. There is no overflow on mid+1 because mid ≤ X_MAX-1.

## Structure
- Shared fixed-point header holds `TOTAL_WIDTH`, `FRAC_BITS`, `ONE`, `X_MAX` (π) and the state encodings (IDLE=0, SEARCH=1, DONE=2).
- One sub-module: a single combinational `cosine_approx` instance driven by mid. No other instances.
- Registers: state, y, lo, hi, cnt (3 bits), sat.

## Test plan
- `y_in`=16 → `x_out`=0, `sat`=0, `out_valid` exactly 6 cycles after accept.
- `y_in`=100 → `x_out`=0, `sat`=1. `y_in`=-101 → `x_out`=50, `sat`=1.
- **Full sweep:** `y_in` from -101 to 100, with `out_ready` held high.
  - Each `x_out` must equal a brute-force scan for the smallest x in 0..50 with `cosine_approx`(x) ≤ clamp(`y_in`).
  - `y_in`=0 must land at the π/2 crossing, 25 or 26 per the scan.
- **Backpressure:**
  - `out_ready` held low for 10 cycles in DONE → `out_valid`, `x_out` and `sat` stable, `in_ready`=0, and an `in_valid` pulse meanwhile is ignored.
  - Releasing `out_ready` → `in_ready`=1 in the next cycle.
- **Reset mid-operation:** assert `rst_n`=0 three cycles into SEARCH → `out_valid`=0, `x_out`=0, `sat`=0, `in_ready`=1 with no clock edge needed. A fresh request for `y_in`=-16 then returns 50 after 6 cycles.
